// File: rtl/pc_out_arbiter.sv
// Weighted round-robin arbiter sharing one registered output channel between
// NREQ word sources; grants are held for a whole message (until in_last).
module pc_out_arbiter #(
  parameter int NREQ    = 3,
  parameter int N       = 35,
  parameter int NWEIGHT = 4,
  localparam int GW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ*N-1:0]     in_d,
  input  logic [NREQ-1:0]       in_last,
  input  logic [NREQ-1:0]       in_v,
  output logic [NREQ-1:0]       in_a,
  output logic [N-1:0]          out_d,
  output logic                  out_v,
  input  logic                  out_a,
  input  logic [NREQ-1:0]       conf_en,
  input  logic [NREQ*NWEIGHT-1:0] conf_wt,
  output logic [GW-1:0]         grant,
  output logic                  busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam int unsigned NREQ_U = NREQ;

  logic [0:0]         state_q, state_d;
  logic [GW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [NWEIGHT-1:0] credit_q, credit_d;
  logic [N-1:0]       out_d_q, out_d_d;
  logic               out_v_q, out_v_d;

  logic               found;
  logic [GW-1:0]      pick;
  logic [NWEIGHT-1:0] pick_wt;
  logic [NWEIGHT-1:0] credit_dec;
  logic               accept;

  function automatic logic [GW-1:0] wrap_inc(input logic [GW-1:0] base,
                                             input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NREQ_U) s = s - NREQ_U;
    return GW'(s);
  endfunction

  // Round-robin scan starting at rr_ptr; first enabled and valid source wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int unsigned k = 0; k < NREQ_U; k++) begin
      if (!found && conf_en[wrap_inc(rr_ptr_q, k)] && in_v[wrap_inc(rr_ptr_q, k)]) begin
        found = 1'b1;
        pick  = wrap_inc(rr_ptr_q, k);
      end
    end
  end

  assign pick_wt    = conf_wt[32'(pick)*NWEIGHT +: NWEIGHT];
  assign credit_dec = (credit_q != '0) ? credit_q - NWEIGHT'(1) : '0;
  assign accept     = (state_q == BUSY) && in_v[grant_q] && (!out_v_q || out_a);

  always_comb begin
    in_a = '0;
    if (state_q == BUSY) in_a[grant_q] = accept;
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    credit_d = credit_q;
    out_d_d  = out_d_q;
    out_v_d  = out_v_q && !out_a;
    if (state_q == IDLE) begin
      if (found) begin
        grant_d = pick;
        state_d = BUSY;
        // Leftover credit is only honoured when the pointer source wins again.
        if (!(pick == rr_ptr_q && credit_q != '0)) begin
          credit_d = (pick_wt == '0) ? NWEIGHT'(1) : pick_wt;
          rr_ptr_d = pick;
        end
      end
    end else if (accept) begin
      out_d_d = in_d[32'(grant_q)*N +: N];
      out_v_d = 1'b1;
      if (in_last[grant_q]) begin
        credit_d = credit_dec;
        state_d  = IDLE;
        if (credit_dec == '0) rr_ptr_d = wrap_inc(grant_q, 1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      credit_q <= '0;
      out_d_q  <= '0;
      out_v_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      credit_q <= credit_d;
      out_d_q  <= out_d_d;
      out_v_q  <= out_v_d;
    end
  end

  assign out_d = out_d_q;
  assign out_v = out_v_q;
  assign grant = grant_q;
  assign busy  = (state_q == BUSY);

endmodule

// File: tb/tb_pc_out_arbiter.sv
// Scoreboard bench for pc_out_arbiter: per-source word queues drive the inputs,
// expected output words are queued in hand-derived order and popped by a monitor.
module tb_pc_out_arbiter;
  localparam int NREQ = 3;
  localparam int N    = 35;
  localparam int NW   = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ*N-1:0]    in_d;
  logic [NREQ-1:0]      in_last;
  logic [NREQ-1:0]      in_v;
  logic [NREQ-1:0]      in_a;
  logic [N-1:0]         out_d;
  logic                 out_v;
  logic                 out_a;
  logic [NREQ-1:0]      conf_en;
  logic [NREQ*NW-1:0]   conf_wt;
  logic [1:0]           grant;
  logic                 busy;

  pc_out_arbiter #(.NREQ(NREQ), .N(N), .NWEIGHT(NW)) dut (
    .clk(clk), .reset(reset), .in_d(in_d), .in_last(in_last), .in_v(in_v),
    .in_a(in_a), .out_d(out_d), .out_v(out_v), .out_a(out_a),
    .conf_en(conf_en), .conf_wt(conf_wt), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] d;
    logic         last;
  } wrd_t;

  wrd_t          src_q[NREQ][$];
  logic [N-1:0]  exp_q[$];
  int            pop_cyc[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            stall_cnt = 0;
  logic [NREQ-1:0] took = '0;
  logic [NREQ-1:0] gap_en = '0;

  function automatic logic [N-1:0] mkw(input int s, input int m, input int w);
    return N'((s + 1) * 65536 + m * 256 + w);
  endfunction

  task automatic load(input int s, input int m, input int nw);
    wrd_t x;
    for (int w = 0; w < nw; w++) begin
      x.d = mkw(s, m, w);
      x.last = (w == nw - 1);
      src_q[s].push_back(x);
    end
  endtask

  task automatic expect_msg(input int s, input int m, input int nw);
    for (int w = 0; w < nw; w++) exp_q.push_back(mkw(s, m, w));
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Source driver and downstream ack: update just after the rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    for (int i = 0; i < NREQ; i++) begin
      if (took[i] && src_q[i].size() > 0) src_q[i].delete(0);
      if (src_q[i].size() > 0 && !(gap_en[i] && (cyc % 2 == 1))) begin
        in_v[i]          = 1'b1;
        in_d[i*N +: N]   = src_q[i][0].d;
        in_last[i]       = src_q[i][0].last;
      end else begin
        in_v[i]          = 1'b0;
        in_d[i*N +: N]   = '0;
        in_last[i]       = 1'b0;
      end
    end
    took = '0;
    if (stall_cnt > 0) begin
      out_a = 1'b0;
      stall_cnt--;
    end else begin
      out_a = 1'b1;
    end
  end

  // Monitor: a word transfers at the next rising edge when out_v & out_a.
  always @(negedge clk) begin
    took = in_v & in_a;
    if (reset && out_v && out_a) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got %0h expected none", out_d);
      end else begin
        if (out_d !== exp_q[0]) begin
          errors++;
          $display("FAIL out_word: got %0h expected %0h", out_d, exp_q[0]);
        end
        exp_q.delete(0);
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic do_reset(input logic [NREQ-1:0] en, input logic [NREQ*NW-1:0] wt);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) src_q[i].delete();
    exp_q.delete();
    pop_cyc.delete();
    gap_en = '0;
    stall_cnt = 0;
    conf_en = en;
    conf_wt = wt;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_exp(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d words pending expected 0", name, exp_q.size());
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_outv(input string name, input int budget);
    int n = 0;
    while (!out_v && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!out_v) begin
      checks++;
      errors++;
      $display("FAIL %s_wait_outv: got 0 expected 1", name);
    end
  endtask

  task automatic wait_busy(input int budget);
    int n = 0;
    while (!busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!busy) begin
      checks++;
      errors++;
      $display("FAIL wait_busy: got 0 expected 1");
    end
  endtask

  logic [N-1:0] held;

  initial begin
    reset   = 1'b0;
    in_v    = '0;
    in_d    = '0;
    in_last = '0;
    out_a   = 1'b1;
    conf_en = '0;
    conf_wt = '0;
    #1;
    chk("rst_out_v", 64'(out_v), 64'd0);
    chk("rst_out_d", 64'(out_d), 64'd0);
    chk("rst_in_a",  64'(in_a),  64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_busy",  64'(busy),  64'd0);

    // Single source, 3-word message: out_v high for 3 cycles from 2 cycles after in_v.
    do_reset(3'b001, {4'd1, 4'd1, 4'd1});
    @(negedge clk);
    load(0, 0, 3);
    expect_msg(0, 0, 3);
    repeat (3) @(negedge clk);
    chk("t1_outv_c2", 64'(out_v), 64'd1);
    @(negedge clk);
    chk("t1_outv_c3", 64'(out_v), 64'd1);
    @(negedge clk);
    chk("t1_outv_c4", 64'(out_v), 64'd1);
    @(negedge clk);
    chk("t1_outv_c5", 64'(out_v), 64'd0);
    wait_exp("t1", 50);

    // Round robin, weights 1: 0,1,2,0,1,2 with one idle cycle between words.
    do_reset(3'b111, {4'd1, 4'd1, 4'd1});
    @(negedge clk);
    for (int m = 0; m < 2; m++)
      for (int s = 0; s < NREQ; s++) load(s, m, 1);
    for (int m = 0; m < 2; m++)
      for (int s = 0; s < NREQ; s++) expect_msg(s, m, 1);
    wait_exp("t2", 100);
    chk("t2_count", 64'(pop_cyc.size()), 64'd6);
    for (int k = 1; k < pop_cyc.size(); k++)
      chk("t2_spacing", 64'(pop_cyc[k] - pop_cyc[k-1]), 64'd2);

    // Weights 2,1,1: 0,0,1,2,0,0,1,2.
    do_reset(3'b111, {4'd1, 4'd1, 4'd2});
    @(negedge clk);
    for (int m = 0; m < 4; m++) load(0, m, 1);
    for (int m = 0; m < 2; m++) begin
      load(1, m, 1);
      load(2, m, 1);
    end
    expect_msg(0, 0, 1); expect_msg(0, 1, 1); expect_msg(1, 0, 1); expect_msg(2, 0, 1);
    expect_msg(0, 2, 1); expect_msg(0, 3, 1); expect_msg(1, 1, 1); expect_msg(2, 1, 1);
    wait_exp("t3", 100);

    // Gapped 4-word message from source 0 is not interleaved with source 1.
    do_reset(3'b111, {4'd1, 4'd1, 4'd1});
    @(negedge clk);
    load(0, 0, 4);
    expect_msg(0, 0, 4);
    expect_msg(1, 0, 1);
    wait_busy(20);
    gap_en = 3'b001;
    load(1, 0, 1);
    wait_exp("t4", 100);

    // Downstream stall for 5 cycles mid-message.
    do_reset(3'b001, {4'd1, 4'd1, 4'd1});
    @(negedge clk);
    load(0, 0, 4);
    expect_msg(0, 0, 4);
    wait_outv("t5", 20);
    stall_cnt = 5;
    @(negedge clk);
    held = out_d;
    chk("t5_stall_outv", 64'(out_v), 64'd1);
    chk("t5_stall_in_a", 64'(in_a), 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t5_hold_outv", 64'(out_v), 64'd1);
      chk("t5_hold_outd", 64'(out_d), 64'(held));
      chk("t5_hold_in_a", 64'(in_a), 64'd0);
    end
    wait_exp("t5", 60);

    // Source 1 disabled: only 0 and 2 alternate; zero weights act as 1.
    do_reset(3'b101, {4'd0, 4'd1, 4'd0});
    @(negedge clk);
    for (int m = 0; m < 2; m++)
      for (int s = 0; s < NREQ; s++) load(s, m, 1);
    expect_msg(0, 0, 1); expect_msg(2, 0, 1); expect_msg(0, 1, 1); expect_msg(2, 1, 1);
    wait_exp("t6", 100);
    repeat (6) @(negedge clk);

    // Reset mid-message clears outputs at once and the pointer restarts at 0.
    do_reset(3'b111, {4'd1, 4'd1, 4'd1});
    @(negedge clk);
    load(0, 0, 1);
    expect_msg(0, 0, 1);
    wait_exp("t7a", 40);
    load(1, 0, 4);
    expect_msg(1, 0, 4);
    wait_outv("t7", 20);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t7_rst_out_v", 64'(out_v), 64'd0);
    chk("t7_rst_out_d", 64'(out_d), 64'd0);
    chk("t7_rst_in_a",  64'(in_a),  64'd0);
    chk("t7_rst_grant", 64'(grant), 64'd0);
    chk("t7_rst_busy",  64'(busy),  64'd0);
    for (int i = 0; i < NREQ; i++) src_q[i].delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    load(1, 1, 1);
    load(0, 1, 1);
    expect_msg(0, 1, 1);
    expect_msg(1, 1, 1);
    wait_exp("t7b", 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
